// File: rtl/bsg_cgol_pkg.sv
// -----------------------------------------------------------------------------
// bsg_cgol_pkg
//   Shared types and elaboration-time helpers for the Game-of-Life job
//   scheduling logic.
//   Contents:
//     bsg_cgol_sched_state_e : scheduler FSM state encoding (2 bits)
//     safe_clog2()           : ceil(log2(n)), never less than 1
//     owner_width()          : bit width of a requester id
// -----------------------------------------------------------------------------
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eISSUE = 2'd1,
    eRUN   = 2'd2,
    eRESP  = 2'd3
  } bsg_cgol_sched_state_e;

  // A width of 0 is never returned, so single-entry ranges still get a
  // usable 1-bit field.
  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int owner_width(input int num_req);
    return safe_clog2(num_req);
  endfunction

endpackage

// File: rtl/bsg_cgol_rr_arb.sv
// -----------------------------------------------------------------------------
// bsg_cgol_rr_arb
//   Purely combinational round-robin arbiter. The search starts at the
//   requester just after last_grant and wraps modulo num_req_p, so the most
//   recently served requester has the lowest priority.
//   Ports:
//     req        in  [num_req_p-1:0]   request vector
//     last_grant in  [id_width_lp-1:0] id of the most recent winner
//     grant      out [num_req_p-1:0]   one-hot grant (all-zero if no request)
//     grant_id   out [id_width_lp-1:0] encoded id of the winner
// -----------------------------------------------------------------------------
module bsg_cgol_rr_arb
  import bsg_cgol_pkg::*;
#(
  parameter  int num_req_p   = 4,
  localparam int id_width_lp = owner_width(num_req_p)
) (
  input  logic [num_req_p-1:0]   req,
  input  logic [id_width_lp-1:0] last_grant,
  output logic [num_req_p-1:0]   grant,
  output logic [id_width_lp-1:0] grant_id
);

  logic [id_width_lp-1:0] idx;
  logic                   found;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the loop leaves a value held and no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = id_width_lp'((int'(last_grant) + i) % num_req_p);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_cgol_job_sched.sv
// -----------------------------------------------------------------------------
// bsg_cgol_job_sched
//   Shares one Game-of-Life engine among num_req_p requesters. One job at a
//   time is granted round-robin, forwarded to the engine, timed while it runs,
//   and its completion is routed back to the owning requester together with
//   the measured run-cycle count.
//   Ports:
//     clk_i         in   clock
//     reset_n_i     in   synchronous active-low reset
//     req_v_i       in   [num_req_p]   per-requester job valid
//     req_frames_i  in   [num_req_p*game_len_width_lp] frame counts, slice k
//     req_ready_o   out  [num_req_p]   one-hot grant (eIDLE only)
//     resp_v_o      out  [num_req_p]   one-hot job-done valid
//     resp_yumi_i   in   [num_req_p]   per-requester done acknowledge
//     resp_cycles_o out  [cycle_width_p] saturating engine run-cycle count
//     eng_frames_o  out  [game_len_width_lp] frame count to the engine
//     eng_v_o       out  job valid to the engine
//     eng_ready_i   in   engine ready
//     eng_v_i       in   engine done valid
//     eng_yumi_o    out  engine done acknowledge
//     owner_o       out  [owner id width] current job owner
//     busy_o        out  high whenever a job is in flight
// -----------------------------------------------------------------------------
module bsg_cgol_job_sched
  import bsg_cgol_pkg::*;
#(
  parameter  int num_req_p         = 4,
  parameter  int max_game_length_p = 1024,
  parameter  int cycle_width_p     = 16,
  localparam int game_len_width_lp = safe_clog2(max_game_length_p),
  localparam int id_width_lp       = owner_width(num_req_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*game_len_width_lp-1:0] req_frames_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  input  logic [num_req_p-1:0]                   resp_yumi_i,
  output logic [cycle_width_p-1:0]               resp_cycles_o,
  output logic [game_len_width_lp-1:0]           eng_frames_o,
  output logic                                   eng_v_o,
  input  logic                                   eng_ready_i,
  input  logic                                   eng_v_i,
  output logic                                   eng_yumi_o,
  output logic [id_width_lp-1:0]                 owner_o,
  output logic                                   busy_o
);

  bsg_cgol_sched_state_e state_r, state_n;

  logic [id_width_lp-1:0]       last_grant_r;
  logic [id_width_lp-1:0]       owner_r;
  logic [game_len_width_lp-1:0] frames_r;
  logic [cycle_width_p-1:0]     count_r;

  logic [num_req_p-1:0]         grant;
  logic [id_width_lp-1:0]       grant_id;
  logic                         req_hs;
  logic                         issue_hs;
  logic                         resp_hs;

  bsg_cgol_rr_arb #(
    .num_req_p (num_req_p)
  ) arb (
    .req        (req_v_i),
    .last_grant (last_grant_r),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req_hs   = (state_r == eIDLE) && (|req_v_i);
  assign issue_hs = (state_r == eISSUE) && eng_ready_i;
  assign resp_hs  = (state_r == eRESP) && eng_v_i && resp_yumi_i[owner_r];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= eIDLE;
    else            state_r <= state_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      eIDLE:  if (req_hs)   state_n = eISSUE;
      eISSUE: if (issue_hs) state_n = eRUN;
      eRUN:   if (eng_v_i)  state_n = eRESP;
      eRESP:  if (resp_hs)  state_n = eIDLE;
      default:              state_n = eIDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. eng_v_o, eng_frames_o, owner_o and busy_o come from registers
  // only; the grant and the done handshake are combinational pass-through.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_o   = '0;
    resp_v_o      = '0;
    eng_yumi_o    = 1'b0;
    eng_v_o       = (state_r == eISSUE);
    eng_frames_o  = frames_r;
    owner_o       = owner_r;
    busy_o        = (state_r != eIDLE);
    resp_cycles_o = count_r;
    if (state_r == eIDLE) req_ready_o = grant;
    if (state_r == eRESP) begin
      resp_v_o[owner_r] = eng_v_i;
      eng_yumi_o        = resp_hs;
    end
  end

  // ---------------------------------------------------------------------------
  // Job datapath: owner, frames, arbitration pointer and run-cycle counter
  // ---------------------------------------------------------------------------
  // NOTE: only these few control registers are reset; there is no storage
  // array here, so a full reset costs nothing and makes outputs defined.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_grant_r <= id_width_lp'(num_req_p - 1);
      owner_r      <= '0;
      frames_r     <= '0;
      count_r      <= '0;
    end else begin
      if (req_hs) begin
        last_grant_r <= grant_id;
        owner_r      <= grant_id;
        frames_r     <= req_frames_i[grant_id*game_len_width_lp +: game_len_width_lp];
        count_r      <= '0;
      end
      // The done cycle itself is not counted, and the count sticks at all-ones
      // rather than wrapping on very long games.
      if ((state_r == eRUN) && !eng_v_i && (count_r != '1)) begin
        count_r <= count_r + cycle_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsg_cgol_job_sched.sv
// -----------------------------------------------------------------------------
// tb_bsg_cgol_job_sched
//   Self-checking bench for bsg_cgol_job_sched. Two instances run in lock-step
//   on the same stimulus: one with the default 16-bit cycle counter and one
//   with a 4-bit counter to exercise saturation. Jobs come from a table; the
//   expected owner and cycle counts are queued at the request handshake and
//   popped when the response appears.
// -----------------------------------------------------------------------------
module tb_bsg_cgol_job_sched;

  localparam int N  = 4;
  localparam int FW = 10;
  localparam int CW = 16;
  localparam int SW = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v;
  logic [N*FW-1:0] req_frames;
  logic [N-1:0]    resp_yumi;
  logic            eng_ready;
  logic            eng_v;

  logic [N-1:0]  req_ready, resp_v;
  logic [CW-1:0] resp_cycles;
  logic [FW-1:0] eng_frames;
  logic          eng_v_out, eng_yumi, busy;
  logic [1:0]    owner;

  logic [N-1:0]  s_req_ready, s_resp_v;
  logic [SW-1:0] s_resp_cycles;
  logic [FW-1:0] s_eng_frames;
  logic          s_eng_v_out, s_eng_yumi, s_busy;
  logic [1:0]    s_owner;

  bsg_cgol_job_sched #(.num_req_p(N), .max_game_length_p(1024), .cycle_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_frames_i(req_frames),
    .req_ready_o(req_ready), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
    .resp_cycles_o(resp_cycles), .eng_frames_o(eng_frames), .eng_v_o(eng_v_out),
    .eng_ready_i(eng_ready), .eng_v_i(eng_v), .eng_yumi_o(eng_yumi),
    .owner_o(owner), .busy_o(busy)
  );

  bsg_cgol_job_sched #(.num_req_p(N), .max_game_length_p(1024), .cycle_width_p(SW)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_frames_i(req_frames),
    .req_ready_o(s_req_ready), .resp_v_o(s_resp_v), .resp_yumi_i(resp_yumi),
    .resp_cycles_o(s_resp_cycles), .eng_frames_o(s_eng_frames), .eng_v_o(s_eng_v_out),
    .eng_ready_i(eng_ready), .eng_v_i(eng_v), .eng_yumi_o(s_eng_yumi),
    .owner_o(s_owner), .busy_o(s_busy)
  );

  typedef struct {
    logic [N-1:0]          mask;
    logic [N-1:0][FW-1:0]  frames;
    int                    ready_delay;
    int                    run_len;     // eng_v_i asserted run_len cycles after the engine handshake
    int                    yumi_delay;
    int                    exp_owner;
  } vec_t;

  typedef struct {
    int owner;
    int cyc;
    int cyc_sat;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0][FW-1:0] pattern(input int base);
    logic [N-1:0][FW-1:0] f;
    for (int k = 0; k < N; k++) f[k] = FW'(base + 37 * k);
    return f;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   req_ready,   0);
    check({tag, "_resp_v"},  resp_v,      0);
    check({tag, "_cycles"},  resp_cycles, 0);
    check({tag, "_frames"},  eng_frames,  0);
    check({tag, "_eng_v"},   eng_v_out,   0);
    check({tag, "_yumi"},    eng_yumi,    0);
    check({tag, "_owner"},   owner,       0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_s_busy"},  s_busy,      0);
    check({tag, "_s_cyc"},   s_resp_cycles, 0);
  endtask

  task automatic run_job(input vec_t v);
    exp_t e;
    logic [N-1:0] own_hot;
    own_hot    = N'(1) << v.exp_owner;
    req_v      = v.mask;
    req_frames = v.frames;
    #1;
    check("idle_busy", busy, 0);
    check("grant", req_ready, own_hot);
    check("grant_sat", s_req_ready, own_hot);
    sb.push_back('{owner: v.exp_owner, cyc: min_int(v.run_len - 1, (1 << CW) - 1),
                   cyc_sat: min_int(v.run_len - 1, (1 << SW) - 1)});
    step();
    check("issue_v", eng_v_out, 1);
    check("issue_frames", eng_frames, v.frames[v.exp_owner]);
    check("owner", owner, v.exp_owner);
    check("ready_closed", req_ready, 0);
    eng_ready = 1'b0;
    for (int c = 0; c < v.ready_delay; c++) begin
      step();
      check("hold_v", eng_v_out, 1);
      check("hold_frames", eng_frames, v.frames[v.exp_owner]);
    end
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    for (int c = 0; c < v.run_len - 1; c++) step();
    check("run_eng_v", eng_v_out, 0);
    check("run_busy", busy, 1);
    eng_v = 1'b1;
    #1;
    check("run_no_resp", resp_v, 0);
    step();
    for (int c = 0; c < v.yumi_delay; c++) begin
      resp_yumi = (c % 2 == 0) ? ~own_hot : '0;
      #1;
      check("stall_yumi", eng_yumi, 0);
      check("stall_resp_v", resp_v, own_hot);
      step();
    end
    resp_yumi = own_hot;
    #1;
    check("eng_yumi", eng_yumi, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("resp_v", resp_v, N'(1) << e.owner);
      check("resp_cycles", resp_cycles, e.cyc);
      check("resp_cycles_sat", s_resp_cycles, e.cyc_sat);
    end
    step();
    resp_yumi = '0;
    eng_v     = 1'b0;
    check("back_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t rv;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{mask: 4'hF, frames: pattern(100 + 5 * i), ready_delay: 0,
                  run_len: 2 + i, yumi_delay: 0, exp_owner: i % 4};
    vecs[8]            = '{mask: 4'b0100, frames: pattern(300), ready_delay: 0,
                           run_len: 7, yumi_delay: 0, exp_owner: 2};
    vecs[8].frames[2]  = FW'(5);
    vecs[9]  = '{mask: 4'b1010, frames: pattern(400), ready_delay: 3,
                 run_len: 5, yumi_delay: 0, exp_owner: 3};
    vecs[10] = '{mask: 4'b0011, frames: pattern(500), ready_delay: 0,
                 run_len: 3, yumi_delay: 4, exp_owner: 0};
    vecs[11] = '{mask: 4'b0010, frames: '0, ready_delay: 0,
                 run_len: 1, yumi_delay: 0, exp_owner: 1};
    vecs[12] = '{mask: 4'b1000, frames: pattern(700), ready_delay: 0,
                 run_len: 41, yumi_delay: 0, exp_owner: 3};

    req_v = '0; req_frames = '0; resp_yumi = '0; eng_ready = 1'b0; eng_v = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_job(vecs[i]);

    // Abandon a job mid-run with a one-cycle reset.
    req_v      = 4'b0100;
    req_frames = pattern(800);
    #1;
    check("abort_grant", req_ready, 4'b0100);
    step();
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    req_v     = '0;
    repeat (3) step();
    check("abort_running", busy, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_all_zero("mid_reset");

    rv = '{mask: 4'hF, frames: pattern(900), ready_delay: 1,
           run_len: 4, yumi_delay: 1, exp_owner: 0};
    run_job(rv);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
